// File: rtl/trace_pkg.sv
// Shared types and constants for the instruction-trace capture unit.
package trace_pkg;

  localparam int unsigned XLEN = 32;

  // One recorded fetch: program counter and the instruction word seen with it.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } trace_entry_t;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    DONE    = 2'd1,
    TIMEOUT = 2'd2
  } trace_state_t;

  localparam logic [3:0] STORE_WORD_EN = 4'b1111;

endpackage

// File: rtl/instr_trace_capture_if.sv
// Snooped CPU buses plus the host drain port and status of the trace unit.
interface instr_trace_capture_if;

  logic [31:0] i_mem_addr;
  logic [31:0] i_mem_rdata;
  logic [31:0] d_mem_addr;
  logic [31:0] d_mem_wdata;
  logic [3:0]  d_mem_wen;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_pc;
  logic [31:0] rd_instr;
  logic        done;
  logic        timeout;
  logic        overflow;
  logic [31:0] cycle_count;
  logic [31:0] fetch_count;

  // CPU / debug host side.
  modport master (
    output i_mem_addr, i_mem_rdata, d_mem_addr, d_mem_wdata, d_mem_wen, rd_ready,
    input  rd_valid, rd_pc, rd_instr, done, timeout, overflow, cycle_count, fetch_count
  );

  // Trace unit side.
  modport slave (
    input  i_mem_addr, i_mem_rdata, d_mem_addr, d_mem_wdata, d_mem_wen, rd_ready,
    output rd_valid, rd_pc, rd_instr, done, timeout, overflow, cycle_count, fetch_count
  );

endinterface

// File: rtl/trace_fifo.sv
// Generic show-ahead synchronous FIFO; head word is visible on rdata while not empty.
module trace_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; reset discards contents by re-aligning the pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_trace_capture.sv
// Snoops CPU fetch/store buses, buffers new fetches and flags completion or timeout.
module instr_trace_capture #(
  parameter int unsigned DEPTH      = 32,
  parameter logic [31:0] PROG_LIMIT = 32'd96,
  parameter logic [31:0] END_ADDR   = 32'h300,
  parameter logic [31:0] END_DATA   = 32'h1,
  parameter int unsigned TIMEOUT    = 200
) (
  input  logic                        clk,
  input  logic                        rst,
  instr_trace_capture_if.slave        bus
);

  trace_pkg::trace_state_t state_q;
  trace_pkg::trace_entry_t push_entry;
  trace_pkg::trace_entry_t head_entry;

  logic [31:0] last_pc_q;
  logic [31:0] cycle_count_q;
  logic [31:0] fetch_count_q;
  logic        done_q;
  logic        timeout_q;
  logic        overflow_q;

  logic fifo_full;
  logic fifo_empty;
  logic fetch_det_c;
  logic end_det_c;
  logic timeout_det_c;
  logic drop_c;

  // A new fetch is a PC change inside the program region while still capturing.
  assign fetch_det_c   = (state_q == trace_pkg::CAPTURE) &&
                         (bus.i_mem_addr != last_pc_q) &&
                         (bus.i_mem_addr < PROG_LIMIT);
  assign end_det_c     = (bus.d_mem_wen == trace_pkg::STORE_WORD_EN) &&
                         (bus.d_mem_addr == END_ADDR) &&
                         (bus.d_mem_wdata == END_DATA);
  assign timeout_det_c = (cycle_count_q > TIMEOUT);
  // Full buffer with no pop this cycle cannot take the fetch.
  assign drop_c        = fetch_det_c && fifo_full && !bus.rd_ready;

  assign push_entry.pc    = bus.i_mem_addr;
  assign push_entry.instr = bus.i_mem_rdata;

  trace_fifo #(
    .WIDTH ($bits(trace_pkg::trace_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fetch_det_c),
    .wdata (push_entry),
    .full  (fifo_full),
    .pop   (bus.rd_ready),
    .rdata (head_entry),
    .empty (fifo_empty)
  );

  // Capture FSM with counters and sticky status flags; DONE beats TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= trace_pkg::CAPTURE;
      last_pc_q     <= 32'hFFFF_FFFF;
      cycle_count_q <= '0;
      fetch_count_q <= '0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      case (state_q)
        trace_pkg::CAPTURE: begin
          cycle_count_q <= cycle_count_q + 32'(1);
          if (fetch_det_c) begin
            last_pc_q     <= bus.i_mem_addr;
            fetch_count_q <= fetch_count_q + 32'(1);
          end
          if (drop_c) overflow_q <= 1'b1;
          if (end_det_c) begin
            state_q <= trace_pkg::DONE;
            done_q  <= 1'b1;
          end else if (timeout_det_c) begin
            state_q   <= trace_pkg::TIMEOUT;
            timeout_q <= 1'b1;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign bus.rd_valid    = !fifo_empty;
  assign bus.rd_pc       = fifo_empty ? 32'h0 : head_entry.pc;
  assign bus.rd_instr    = fifo_empty ? 32'h0 : head_entry.instr;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;
  assign bus.overflow    = overflow_q;
  assign bus.cycle_count = cycle_count_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_trace_capture.sv
// Directed self-checking bench for instr_trace_capture.
module tb_instr_trace_capture;

  localparam int unsigned TB_DEPTH = 8;
  localparam logic [31:0] IDLE_PC  = 32'hFFFF_FF00;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  instr_trace_capture_if bus_if ();

  instr_trace_capture #(.DEPTH(TB_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.i_mem_addr  = IDLE_PC;
    bus_if.i_mem_rdata = 32'h0;
    bus_if.d_mem_addr  = 32'h0;
    bus_if.d_mem_wdata = 32'h0;
    bus_if.d_mem_wen   = 4'b0000;
    bus_if.rd_ready    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
    bus_if.i_mem_addr  = pc;
    bus_if.i_mem_rdata = instr;
    tick();
    bus_if.i_mem_addr  = IDLE_PC;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #12;
    checks++;
    if (bus_if.rd_valid !== 1'b0 || bus_if.done !== 1'b0 || bus_if.timeout !== 1'b0 ||
        bus_if.overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: got valid=%b done=%b to=%b ovf=%b expected all 0",
               bus_if.rd_valid, bus_if.done, bus_if.timeout, bus_if.overflow);
    end
    checks++;
    if (bus_if.cycle_count !== 32'd0 || bus_if.fetch_count !== 32'd0 || bus_if.rd_pc !== 32'd0) begin
      failures++;
      $display("FAIL reset_counts: got cyc=%0d fetch=%0d pc=%h expected 0 0 0",
               bus_if.cycle_count, bus_if.fetch_count, bus_if.rd_pc);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fetch_order();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_in [3];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
    exp_in[0] = 32'hA000_0013; exp_in[1] = 32'hA100_0093; exp_in[2] = 32'hA200_0113;
    do_reset();
    bus_if.i_mem_addr = 32'h0; bus_if.i_mem_rdata = exp_in[0];
    tick();
    checks++;
    if (bus_if.rd_valid !== 1'b1 || bus_if.rd_pc !== 32'h0) begin
      failures++;
      $display("FAIL push_latency: got valid=%b pc=%h expected 1 00000000", bus_if.rd_valid, bus_if.rd_pc);
    end
    bus_if.i_mem_addr = 32'h4; bus_if.i_mem_rdata = exp_in[1];
    repeat (3) tick();
    bus_if.i_mem_addr = 32'h8; bus_if.i_mem_rdata = exp_in[2];
    tick();
    idle_inputs();
    tick();
    checks++;
    if (bus_if.fetch_count !== 32'd3) begin
      failures++;
      $display("FAIL fetch_count_held_pc: got %0d expected 3", bus_if.fetch_count);
    end
    bus_if.rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus_if.rd_valid !== 1'b1 || bus_if.rd_pc !== exp_pc[i] || bus_if.rd_instr !== exp_in[i]) begin
        failures++;
        $display("FAIL fetch_head_%0d: got valid=%b pc=%h instr=%h expected 1 %h %h",
                 i, bus_if.rd_valid, bus_if.rd_pc, bus_if.rd_instr, exp_pc[i], exp_in[i]);
      end
      tick();
    end
    bus_if.rd_ready = 1'b0;
    checks++;
    if (bus_if.rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL fetch_drained: got valid=%b expected 0", bus_if.rd_valid);
    end
  endtask

  task automatic test_prog_limit();
    do_reset();
    fetch(32'h60, 32'hDEAD_BEEF);
    checks++;
    if (bus_if.rd_valid !== 1'b0 || bus_if.fetch_count !== 32'd0) begin
      failures++;
      $display("FAIL limit_excluded: got valid=%b fetch=%0d expected 0 0", bus_if.rd_valid, bus_if.fetch_count);
    end
    fetch(32'h5C, 32'h1234_5678);
    checks++;
    if (bus_if.rd_valid !== 1'b1 || bus_if.rd_pc !== 32'h5C || bus_if.fetch_count !== 32'd1) begin
      failures++;
      $display("FAIL limit_below: got valid=%b pc=%h fetch=%0d expected 1 0000005c 1",
               bus_if.rd_valid, bus_if.rd_pc, bus_if.fetch_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < TB_DEPTH + 2; i++) fetch(32'(i), 32'(100 + i));
    checks++;
    if (bus_if.overflow !== 1'b1 || bus_if.fetch_count !== 32'(TB_DEPTH + 2)) begin
      failures++;
      $display("FAIL overflow_set: got ovf=%b fetch=%0d expected 1 %0d",
               bus_if.overflow, bus_if.fetch_count, TB_DEPTH + 2);
    end
    bus_if.rd_ready = 1'b1;
    for (int i = 0; i < TB_DEPTH; i++) begin
      checks++;
      if (bus_if.rd_valid !== 1'b1 || bus_if.rd_pc !== 32'(i) || bus_if.rd_instr !== 32'(100 + i)) begin
        failures++;
        $display("FAIL overflow_drain_%0d: got valid=%b pc=%h instr=%h expected 1 %h %h",
                 i, bus_if.rd_valid, bus_if.rd_pc, bus_if.rd_instr, 32'(i), 32'(100 + i));
      end
      tick();
    end
    bus_if.rd_ready = 1'b0;
    checks++;
    if (bus_if.rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL overflow_empty: got valid=%b expected 0", bus_if.rd_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < TB_DEPTH; i++) fetch(32'(i), 32'(200 + i));
    bus_if.i_mem_addr  = 32'(TB_DEPTH);
    bus_if.i_mem_rdata = 32'(200 + TB_DEPTH);
    bus_if.rd_ready    = 1'b1;
    tick();
    bus_if.i_mem_addr  = IDLE_PC;
    checks++;
    if (bus_if.overflow !== 1'b0 || bus_if.fetch_count !== 32'(TB_DEPTH + 1) || bus_if.rd_pc !== 32'h1) begin
      failures++;
      $display("FAIL full_push_pop: got ovf=%b fetch=%0d head=%h expected 0 %0d 00000001",
               bus_if.overflow, bus_if.fetch_count, bus_if.rd_pc, TB_DEPTH + 1);
    end
    for (int i = 1; i <= TB_DEPTH; i++) begin
      checks++;
      if (bus_if.rd_valid !== 1'b1 || bus_if.rd_pc !== 32'(i) || bus_if.rd_instr !== 32'(200 + i)) begin
        failures++;
        $display("FAIL b2b_drain_%0d: got valid=%b pc=%h instr=%h expected 1 %h %h",
                 i, bus_if.rd_valid, bus_if.rd_pc, bus_if.rd_instr, 32'(i), 32'(200 + i));
      end
      tick();
    end
    bus_if.rd_ready = 1'b0;
  endtask

  task automatic test_done();
    do_reset();
    repeat (3) tick();
    bus_if.d_mem_addr = 32'h300; bus_if.d_mem_wdata = 32'h2; bus_if.d_mem_wen = 4'b1111;
    tick();
    checks++;
    if (bus_if.done !== 1'b0) begin
      failures++;
      $display("FAIL done_wrong_data: got done=%b expected 0", bus_if.done);
    end
    bus_if.d_mem_wdata = 32'h1; bus_if.d_mem_wen = 4'b0001;
    tick();
    checks++;
    if (bus_if.done !== 1'b0) begin
      failures++;
      $display("FAIL done_byte_store: got done=%b expected 0", bus_if.done);
    end
    bus_if.d_mem_wen = 4'b1111;
    bus_if.i_mem_addr = 32'h10; bus_if.i_mem_rdata = 32'hCAFE_0010;
    tick();
    idle_inputs();
    checks++;
    if (bus_if.done !== 1'b1 || bus_if.timeout !== 1'b0 || bus_if.cycle_count !== 32'd6) begin
      failures++;
      $display("FAIL done_set: got done=%b to=%b cyc=%0d expected 1 0 6",
               bus_if.done, bus_if.timeout, bus_if.cycle_count);
    end
    checks++;
    if (bus_if.rd_valid !== 1'b1 || bus_if.rd_pc !== 32'h10 || bus_if.fetch_count !== 32'd1) begin
      failures++;
      $display("FAIL done_edge_fetch: got valid=%b pc=%h fetch=%0d expected 1 00000010 1",
               bus_if.rd_valid, bus_if.rd_pc, bus_if.fetch_count);
    end
    fetch(32'h14, 32'hCAFE_0014);
    repeat (4) tick();
    checks++;
    if (bus_if.cycle_count !== 32'd6 || bus_if.fetch_count !== 32'd1 || bus_if.done !== 1'b1) begin
      failures++;
      $display("FAIL done_frozen: got cyc=%0d fetch=%0d done=%b expected 6 1 1",
               bus_if.cycle_count, bus_if.fetch_count, bus_if.done);
    end
    bus_if.rd_ready = 1'b1;
    tick();
    bus_if.rd_ready = 1'b0;
    checks++;
    if (bus_if.rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL done_drain: got valid=%b expected 0", bus_if.rd_valid);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (201) tick();
    checks++;
    if (bus_if.timeout !== 1'b0 || bus_if.cycle_count !== 32'd201) begin
      failures++;
      $display("FAIL timeout_early: got to=%b cyc=%0d expected 0 201", bus_if.timeout, bus_if.cycle_count);
    end
    tick();
    checks++;
    if (bus_if.timeout !== 1'b1 || bus_if.done !== 1'b0 || bus_if.cycle_count !== 32'd202) begin
      failures++;
      $display("FAIL timeout_set: got to=%b done=%b cyc=%0d expected 1 0 202",
               bus_if.timeout, bus_if.done, bus_if.cycle_count);
    end
    bus_if.d_mem_addr = 32'h300; bus_if.d_mem_wdata = 32'h1; bus_if.d_mem_wen = 4'b1111;
    repeat (3) tick();
    idle_inputs();
    checks++;
    if (bus_if.cycle_count !== 32'd202 || bus_if.done !== 1'b0) begin
      failures++;
      $display("FAIL timeout_terminal: got cyc=%0d done=%b expected 202 0", bus_if.cycle_count, bus_if.done);
    end
    do_reset();
    repeat (201) tick();
    bus_if.d_mem_addr = 32'h300; bus_if.d_mem_wdata = 32'h1; bus_if.d_mem_wen = 4'b1111;
    tick();
    idle_inputs();
    checks++;
    if (bus_if.done !== 1'b1 || bus_if.timeout !== 1'b0) begin
      failures++;
      $display("FAIL done_beats_timeout: got done=%b to=%b expected 1 0", bus_if.done, bus_if.timeout);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 5; i++) fetch(32'(4 * i), 32'(300 + i));
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus_if.rd_valid !== 1'b0 || bus_if.fetch_count !== 32'd0 || bus_if.cycle_count !== 32'd0) begin
      failures++;
      $display("FAIL async_reset: got valid=%b fetch=%0d cyc=%0d expected 0 0 0",
               bus_if.rd_valid, bus_if.fetch_count, bus_if.cycle_count);
    end
    @(negedge clk);
    rst = 1'b0;
    fetch(32'h0, 32'h0BAD_0000);
    checks++;
    if (bus_if.rd_valid !== 1'b1 || bus_if.rd_pc !== 32'h0 || bus_if.rd_instr !== 32'h0BAD_0000 ||
        bus_if.fetch_count !== 32'd1) begin
      failures++;
      $display("FAIL refetch_after_reset: got valid=%b pc=%h instr=%h fetch=%0d expected 1 0 0bad0000 1",
               bus_if.rd_valid, bus_if.rd_pc, bus_if.rd_instr, bus_if.fetch_count);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_fetch_order();
    test_prog_limit();
    test_overflow();
    test_back_to_back();
    test_done();
    test_timeout();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
